tl_client_port: RTL

TileLink initiator port that turns single-command requests from a local agent (core model, DMA stub or verification driver) into TileLink A/C/E channel traffic and collects D channel responses. It sits on the client side of the same A–E interface that the memory responder model serves. It issues one outstanding transaction at a time: Get, PutFullData, AcquireBlock or Release. Multi-beat response data is returned one beat at a time on a registered response port.

---
 rtl/tl_client_port_if.sv | 64 ++++++
 rtl/tl_client_port.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_client_port_if.sv
// TileLink A-E channel bundle between a client port (master) and a responder (slave).
interface tl_client_port_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;

    logic        b_valid;
    logic        b_ready;

    logic        c_valid;
    logic        c_ready;
    logic [2:0]  c_opcode;
    logic [2:0]  c_param;
    logic [3:0]  c_size;
    logic [3:0]  c_source;
    logic [31:0] c_address;
    logic [63:0] c_data;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [3:0]  d_source;
    logic [2:0]  d_sink;
    logic [63:0] d_data;
    logic        d_error;

    logic        e_valid;
    logic        e_ready;
    logic [2:0]  e_sink;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  b_valid,
        output b_ready,
        output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
        input  c_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        output d_ready,
        output e_valid, e_sink,
        input  e_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output b_valid,
        input  b_ready,
        input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
        output c_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        input  d_ready,
        input  e_valid, e_sink,
        output e_ready
    );
endinterface

// File: rtl/tl_client_port.sv
// TileLink client port: one outstanding Get/PutFullData/AcquireBlock/Release at a time,
// D-channel beats returned one per cycle on a registered response port.
module tl_client_port #(
    parameter logic [3:0]  SOURCE_ID = 4'h0,
    parameter logic [15:0] TIMEOUT   = 16'd1024
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_size,
    input  logic [7:0]  cmd_mask,
    input  logic [63:0] cmd_data,

    tl_client_port_if.master tl,

    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_error
);

    localparam logic [1:0]  OP_GET     = 2'd0;
    localparam logic [1:0]  OP_PUT     = 2'd1;
    localparam logic [1:0]  OP_ACQUIRE = 2'd2;
    localparam logic [1:0]  OP_RELEASE = 2'd3;
    localparam logic [15:0] TIMER_LAST = TIMEOUT - 16'd1;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_C,
        WAIT_D,
        SEND_E
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [1:0]  r_op;
    logic [31:0] r_addr;
    logic [3:0]  r_size;
    logic [7:0]  r_mask;
    logic [63:0] r_data;
    logic [7:0]  r_beatCnt;
    logic [15:0] r_timer;
    logic [2:0]  r_sink;

    logic        r_rspValid;
    logic [63:0] r_rspData;
    logic        r_rspLast;
    logic        r_rspError;

    logic        w_accept;
    logic        w_aFire;
    logic        w_cFire;
    logic        w_dFire;
    logic        w_eFire;
    logic        w_opOk;
    logic        w_violation;
    logic        w_multiBeat;
    logic [2:0]  w_shift;
    logic [7:0]  w_lastIdx;
    logic        w_lastBeat;
    logic        w_busy;
    logic        w_timeout;
    logic        w_unused;

    assign w_accept = cmd_valid && (r_state == IDLE);
    assign w_aFire  = (r_state == SEND_A) && tl.a_ready;
    assign w_cFire  = (r_state == SEND_C) && tl.c_ready;
    assign w_dFire  = (r_state == WAIT_D) && tl.d_valid;
    assign w_eFire  = (r_state == SEND_E) && tl.e_ready;
    assign w_busy   = (r_state != IDLE);

    // Only the response opcodes legal for the outstanding command are accepted.
    always_comb begin
        w_opOk = 1'b0;
        case (r_op)
            OP_GET:     w_opOk = (tl.d_opcode == 3'd1);
            OP_PUT:     w_opOk = (tl.d_opcode == 3'd0);
            OP_ACQUIRE: w_opOk = (tl.d_opcode == 3'd5) || (tl.d_opcode == 3'd4);
            OP_RELEASE: w_opOk = (tl.d_opcode == 3'd6);
            default:    w_opOk = 1'b0;
        endcase
    end

    assign w_violation = w_dFire && ((tl.d_source != SOURCE_ID) || !w_opOk);
    assign w_multiBeat = (r_op == OP_GET) || ((r_op == OP_ACQUIRE) && (tl.d_opcode == 3'd5));
    assign w_shift     = 3'(r_size - 4'd3);

    // Bursts beyond 256 beats saturate the 8-bit beat index.
    always_comb begin
        w_lastIdx = 8'd0;
        if (r_size < 4'd3) begin
            w_lastIdx = 8'd0;
        end else if (r_size > 4'd10) begin
            w_lastIdx = 8'hFF;
        end else begin
            w_lastIdx = (8'd1 << w_shift) - 8'd1;
        end
    end

    assign w_lastBeat = !w_multiBeat || (r_beatCnt == w_lastIdx);
    assign w_timeout  = w_busy && !(w_aFire || w_cFire || w_dFire || w_eFire) && (r_timer == TIMER_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_nextState = (cmd_op == OP_RELEASE) ? SEND_C : SEND_A;
                end
            end
            SEND_A: begin
                if (tl.a_ready) begin
                    w_nextState = WAIT_D;
                end
            end
            SEND_C: begin
                if (tl.c_ready) begin
                    w_nextState = WAIT_D;
                end
            end
            WAIT_D: begin
                if (tl.d_valid) begin
                    if (w_violation) begin
                        w_nextState = IDLE;
                    end else if (w_lastBeat) begin
                        w_nextState = (r_op == OP_ACQUIRE) ? SEND_E : IDLE;
                    end
                end
            end
            SEND_E: begin
                if (tl.e_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
        if (w_timeout) begin
            w_nextState = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op   <= 2'd0;
            r_addr <= 32'd0;
            r_size <= 4'd0;
            r_mask <= 8'd0;
            r_data <= 64'd0;
        end else if (w_accept) begin
            r_op   <= cmd_op;
            r_addr <= cmd_addr;
            r_size <= cmd_size;
            r_mask <= cmd_mask;
            r_data <= cmd_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_beatCnt <= 8'd0;
            r_timer   <= 16'd0;
            r_sink    <= 3'd0;
        end else begin
            if (w_accept) begin
                r_beatCnt <= 8'd0;
            end else if (w_dFire) begin
                r_beatCnt <= r_beatCnt + 8'd1;
            end
            if (!w_busy || (w_nextState != r_state) || w_dFire) begin
                r_timer <= 16'd0;
            end else begin
                r_timer <= r_timer + 16'd1;
            end
            if (w_dFire && w_lastBeat && !w_violation && (r_op == OP_ACQUIRE)) begin
                r_sink <= tl.d_sink;
            end
        end
    end

    // A timeout produces a data-less error beat that also closes the transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rspValid <= 1'b0;
            r_rspData  <= 64'd0;
            r_rspLast  <= 1'b0;
            r_rspError <= 1'b0;
        end else begin
            r_rspValid <= w_dFire || w_timeout;
            r_rspLast  <= w_timeout || (w_dFire && (w_lastBeat || w_violation));
            r_rspError <= w_timeout || (w_dFire && (tl.d_error || w_violation));
            if (w_timeout) begin
                r_rspData <= 64'd0;
            end else if (w_dFire) begin
                r_rspData <= tl.d_data;
            end
        end
    end

    assign cmd_ready    = (r_state == IDLE);

    assign tl.a_valid   = (r_state == SEND_A);
    assign tl.a_opcode  = (r_op == OP_PUT) ? 3'd0 : ((r_op == OP_ACQUIRE) ? 3'd6 : 3'd4);
    assign tl.a_param   = (r_op == OP_ACQUIRE) ? 3'd1 : 3'd0;
    assign tl.a_size    = r_size;
    assign tl.a_source  = SOURCE_ID;
    assign tl.a_address = r_addr;
    assign tl.a_mask    = (r_op == OP_PUT) ? r_mask : 8'hFF;
    assign tl.a_data    = (r_op == OP_PUT) ? r_data : 64'd0;

    assign tl.b_ready   = 1'b1;

    assign tl.c_valid   = (r_state == SEND_C);
    assign tl.c_opcode  = 3'd6;
    assign tl.c_param   = 3'd1;
    assign tl.c_size    = r_size;
    assign tl.c_source  = SOURCE_ID;
    assign tl.c_address = r_addr;
    assign tl.c_data    = 64'd0;

    assign tl.d_ready   = (r_state == WAIT_D);

    assign tl.e_valid   = (r_state == SEND_E);
    assign tl.e_sink    = r_sink;

    assign rsp_valid    = r_rspValid;
    assign rsp_data     = r_rspData;
    assign rsp_last     = r_rspLast;
    assign rsp_error    = r_rspError;

    assign w_unused = &{1'b0, tl.b_valid, tl.d_param, tl.d_size};

endmodule
